// File: rtl/axis_spm_config_writer_if.sv
// PS-side write stream into the SPM config writer: one staged word per beat,
// with an optional commit (last) carrying the target register address.
interface axis_spm_config_writer_if;
   logic [31:0] s_wr_tdata;
   logic [3:0]  s_wr_index;
   logic [31:0] s_wr_cfgaddr;
   logic        s_wr_last;
   logic        s_wr_tvalid;
   logic        s_wr_tready;

   modport master (
      output s_wr_tdata, s_wr_index, s_wr_cfgaddr, s_wr_last, s_wr_tvalid,
      input  s_wr_tready
   );

   modport slave (
      input  s_wr_tdata, s_wr_index, s_wr_cfgaddr, s_wr_last, s_wr_tvalid,
      output s_wr_tready
   );
endinterface

// File: rtl/axis_spm_config_writer.sv
// Stages 32-bit words into config_data and pulses config_addr per commit.
// Optional commit counter enabled by defining CFG_COMMIT_COUNT_EN.
module axis_spm_config_writer #(
   parameter int          CFG_DATA_WIDTH = 512,
   parameter int          NWORDS         = CFG_DATA_WIDTH / 32,
   parameter int          HOLD_CYCLES    = 2,
   parameter logic [31:0] IDLE_ADDR      = 32'd0
) (
   input  logic                      a_clk,
   input  logic                      a_resetn,
   axis_spm_config_writer_if.slave   s_wr,
   output logic [31:0]               config_addr,
   output logic [CFG_DATA_WIDTH-1:0] config_data,
   output logic                      busy,
   output logic                      err_idle_addr
`ifdef CFG_COMMIT_COUNT_EN
   ,
   output logic [15:0]               commit_count
`endif
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESENT,
      S_GAP
   } state_e;

   state_e                    state_q, state_d;
   logic [HW-1:0]             hold_q, hold_d;
   logic [31:0]               addr_q, addr_d;
   logic [CFG_DATA_WIDTH-1:0] data_q, data_d;
   logic                      tready_q, tready_d;
   logic                      busy_q, busy_d;
   logic                      err_q, err_d;
   logic                      acc, is_idle_tgt, commit;

   assign acc         = s_wr.s_wr_tvalid & tready_q;
   assign is_idle_tgt = (s_wr.s_wr_cfgaddr == IDLE_ADDR);
   assign commit      = acc & s_wr.s_wr_last & ~is_idle_tgt;

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      addr_d   = addr_q;
      data_d   = data_q;
      err_d    = err_q | (acc & s_wr.s_wr_last & is_idle_tgt);
      // tready_q is only ever high in IDLE, so acc implies IDLE here
      for (int i = 0; i < NWORDS; i++) begin
         if (acc && int'(s_wr.s_wr_index) == i) begin
            data_d[32*i +: 32] = s_wr.s_wr_tdata;
         end
      end
      unique case (state_q)
         S_IDLE: begin
            if (commit) begin
               state_d = S_PRESENT;
               hold_d  = '0;
               addr_d  = s_wr.s_wr_cfgaddr;
            end
         end
         S_PRESENT: begin
            if (hold_q == HOLD_LAST) begin
               state_d = S_GAP;
               addr_d  = IDLE_ADDR;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            addr_d  = IDLE_ADDR;
         end
      endcase
      tready_d = (state_d == S_IDLE);
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge a_clk or negedge a_resetn) begin
      if (!a_resetn) begin
         state_q  <= S_IDLE;
         hold_q   <= '0;
         addr_q   <= IDLE_ADDR;
         data_q   <= '0;
         tready_q <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         tready_q <= tready_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

`ifdef CFG_COMMIT_COUNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 16'(commit);
   end

   always_ff @(posedge a_clk or negedge a_resetn) begin
      if (!a_resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign commit_count = cnt_q;
`endif

   assign s_wr.s_wr_tready = tready_q;
   assign config_addr      = addr_q;
   assign config_data      = data_q;
   assign busy             = busy_q;
   assign err_idle_addr    = err_q;

endmodule

// File: tb/tb_axis_spm_config_writer.sv
// Directed + randomized bench for axis_spm_config_writer against a
// cycle-arithmetic reference model of the commit timeline.
module tb_axis_spm_config_writer;
   localparam int H = 2;

   logic         a_clk = 1'b0;
   logic         a_resetn = 1'b0;
   logic [31:0]  config_addr;
   logic [511:0] config_data;
   logic         busy;
   logic         err_idle_addr;
`ifdef CFG_COMMIT_COUNT_EN
   logic [15:0]  commit_count;
`endif

   axis_spm_config_writer_if wr ();

   axis_spm_config_writer #(
      .CFG_DATA_WIDTH(512),
      .NWORDS(16),
      .HOLD_CYCLES(H),
      .IDLE_ADDR(32'd0)
   ) dut (
      .a_clk(a_clk),
      .a_resetn(a_resetn),
      .s_wr(wr.slave),
      .config_addr(config_addr),
      .config_data(config_data),
      .busy(busy),
      .err_idle_addr(err_idle_addr)
`ifdef CFG_COMMIT_COUNT_EN
      ,
      .commit_count(commit_count)
`endif
   );

   always #5 a_clk = ~a_clk;

   int cyc = 0;
   always @(posedge a_clk) cyc++;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [511:0] got,
                      input logic [511:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // reference model: staging words plus the timeline of the latest commit
   logic [31:0] mw [16];
   bit          have_commit;
   int          last_t;
   logic [31:0] last_addr;
   int          next_ready;
   bit          exp_err;
   int          n_commit;
   bit          mon_en = 1'b0;

   function automatic logic [511:0] exp_data();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[32*i +: 32] = mw[i];
      return v;
   endfunction

   function automatic bit in_present();
      return have_commit && cyc >= last_t + 1 && cyc <= last_t + H;
   endfunction

   function automatic bit in_busy();
      return have_commit && cyc >= last_t + 1 && cyc <= last_t + H + 1;
   endfunction

   always @(negedge a_clk) begin
      if (mon_en) begin
         chk("addr", 512'(config_addr), in_present() ? 512'(last_addr) : 512'd0);
         chk("busy", 512'(busy), 512'(in_busy()));
         chk("tready", 512'(wr.s_wr_tready), 512'(cyc >= next_ready));
         chk("data", config_data, exp_data());
         chk("err", 512'(err_idle_addr), 512'(exp_err));
`ifdef CFG_COMMIT_COUNT_EN
         chk("count", 512'(commit_count), 512'(n_commit[15:0]));
`endif
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mw[i] = '0;
      have_commit = 1'b0;
      exp_err     = 1'b0;
      n_commit    = 0;
      last_t      = 0;
      last_addr   = '0;
   endtask

   // called just after a rising edge
   task automatic do_reset();
      mon_en = 1'b0;
      a_resetn = 1'b0;
      wr.s_wr_tvalid = 1'b0;
      model_reset();
      repeat (2) @(posedge a_clk);
      #1;
      a_resetn = 1'b1;
      next_ready = cyc + 1;
      mon_en = 1'b1;
   endtask

   // offers one beat, holding tvalid until accepted; returns just after the edge
   task automatic beat(input logic [3:0] idx, input logic [31:0] d,
                       input logic last, input logic [31:0] a);
      int req;
      int waited;
      int acc;
      wr.s_wr_index   = idx;
      wr.s_wr_tdata   = d;
      wr.s_wr_last    = last;
      wr.s_wr_cfgaddr = a;
      wr.s_wr_tvalid  = 1'b1;
      req = cyc;
      waited = 0;
      @(negedge a_clk);
      while (wr.s_wr_tready !== 1'b1 && waited < 20) begin
         @(negedge a_clk);
         waited++;
      end
      if (wr.s_wr_tready !== 1'b1) begin
         chk("accept_timeout", 512'd0, 512'd1);
         @(posedge a_clk);
         #1;
         wr.s_wr_tvalid = 1'b0;
         return;
      end
      acc = cyc;
      chk("accept_cycle", 512'(acc), 512'((req > next_ready) ? req : next_ready));
      @(posedge a_clk);
      #1;
      wr.s_wr_tvalid = 1'b0;
      mw[idx] = d;
      if (last) begin
         if (a == 32'd0) begin
            exp_err = 1'b1;
         end else begin
            have_commit = 1'b1;
            last_t      = acc;
            last_addr   = a;
            next_ready  = acc + H + 2;
            n_commit++;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge a_clk);
      #1;
   endtask

   initial begin
      logic [511:0] snap;
      logic [31:0]  ra;
      int           sel;
      wr.s_wr_tvalid  = 1'b0;
      wr.s_wr_tdata   = '0;
      wr.s_wr_index   = '0;
      wr.s_wr_cfgaddr = '0;
      wr.s_wr_last    = 1'b0;
      @(posedge a_clk);
      #1;
      chk("rst_addr", 512'(config_addr), 512'd0);
      chk("rst_data", config_data, 512'd0);
      chk("rst_tready", 512'(wr.s_wr_tready), 512'd0);
      do_reset();

      beat(4'd0, 32'h0000_1000, 1'b0, 32'd0);
      beat(4'd1, 32'hFFFF_F000, 1'b0, 32'd0);
      beat(4'd3, 32'h4000_0000, 1'b1, 32'd1100);
      chk("ex_data128", 512'(config_data[127:0]),
          512'(128'h40000000_00000000_FFFFF000_00001000));
      idle(5);

      beat(4'd0, 32'h1111_1111, 1'b1, 32'd1104);
      beat(4'd0, 32'h2222_2222, 1'b1, 32'd1104);
      idle(5);

      beat(4'd2, 32'hA5A5_A5A5, 1'b1, 32'd0);
      idle(3);

      snap = config_data;
      beat(4'd15, 32'hDEAD_BEEF, 1'b1, 32'd1103);
      chk("w15_top", 512'(config_data[511:480]), 512'(32'hDEAD_BEEF));
      chk("w15_low", 512'(config_data[479:0]), 512'(snap[479:0]));
      idle(5);

      for (int n = 0; n < 60; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0:       ra = 32'd0;
            1, 2:    ra = 32'd1104;
            3:       ra = 32'd1100;
            default: ra = $urandom | 32'd1;
         endcase
         beat(4'($urandom_range(0, 15)), $urandom,
              ($urandom_range(0, 2) == 0), ra);
         if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
      end
      idle(6);

      beat(4'd4, 32'h1234_5678, 1'b1, 32'd1108);
      mon_en = 1'b0;
      a_resetn = 1'b0;
      #1;
      chk("async_addr", 512'(config_addr), 512'd0);
      chk("async_busy", 512'(busy), 512'd0);
      chk("async_tready", 512'(wr.s_wr_tready), 512'd0);
      chk("async_data", config_data, 512'd0);
      chk("async_err", 512'(err_idle_addr), 512'd0);
      idle(1);
      do_reset();
      idle(4);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=%0d exp=0", cyc);
      $fatal(1, "timeout");
   end
endmodule
